moving_average_master: RTL and testbench
========================================

Name: moving_average_master

Overview:
- Selectable-length moving-average (boxcar) filter for a 10-bit unsigned sample stream, wrapped in the standard 8-in/8-out/8-bidir tile pin interface.
- A sample is accepted on each rising edge of strobe_in.
- After each accepted sample the block emits the mean of the last N samples together with a one-cycle strobe_out pulse.
- N is 2, 4, 8 or 16, chosen by a 2-bit select.

Parameters:
- DATA_W, 10, sample and result width.
- NMAX, 16, longest window (history depth).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-high (the legacy name is kept). rst_n=1 clears all state.
- ena  in  1  tile enable. Samples are accepted only while ena=1.
- ui_in  in  8  data_in[7:0].
- uio_in  in  8  Bit assignments:
  - [0] strobe_in
  - [1] unused
  - [3:2] data_in[9:8]
  - [5:4] unused
  - [7:6] filter_select
- uo_out  out  8  data_out[7:0].
- uio_out  out  8  Bit assignments:
  - [1] strobe_out
  - [5:4] data_out[9:8]
  - all other bits 0
- uio_oe  out  8  constant 8'b0011_0010 (bits 1, 4 and 5 driven).

Behaviour:
- Reset: history buffer, all running sums, strobe edge register, data_out and strobe_out are cleared to 0.
- Strobe detect: register strobe_d <= strobe_in.
  - accept = strobe_in & ~strobe_d & ena, evaluated at a clock edge.
  - A held-high or falling strobe never triggers an accept.
- Accept at edge k:
  - The 16-deep shift buffer takes data_in; hist[0]=newest.
  - Four running sums update in parallel: sumN <= sumN + data_in - hist[N-1] (pre-shift value), for N=2, 4, 8, 16.
  - Sum widths are 11, 12, 13 and 14 bits; no overflow is possible.
- Output at edge k+1:
  - data_out <= sum_sel >> log2(N_sel), truncating.
  - strobe_out <= 1.
  - At edge k+2, strobe_out returns to 0 unless a new accept occurred at k+1.
  - data_out holds between updates.
- filter_select mapping: 00→N=2, 01→N=4, 10→N=8, 11→N=16.
  - Sampled at the output edge (k+1).
  - All sums are always maintained, so a select change takes effect on the next output with no transient.
- Start-up: the buffer is zero-filled after reset, so the first N-1 outputs are partial sums divided by N (zero padding).
- Min strobe spacing: one accept per 2 clocks is supported.
- Reset mid-operation: all state clears immediately, including a pending output. The first accept after release behaves as a fresh start.
- Outputs are registered; there is no combinational path from inputs to uo_out/uio_out.

Decomposition:
- Shared package holds:
  - DATA_W and NMAX
  - the select encodings (SEL_N2, SEL_N4, SEL_N8, SEL_N16)
  - the uio bit-position constants
- One sub-module, moving_average_core: strobe edge detect, history buffer, the four running sums, and output register.
- The top level does only pin packing/unpacking and drives uio_oe.

Test Plan:
- Reset check: hold rst_n=1 → data_out=0, strobe_out=0, uio_oe=8'h32, unused uio_out bits 0. Release; no strobe → outputs stay 0.
- Ramp-in, sel=11: constant 1023, 16 strobes → outputs 63, 127, 191, …, 959, 1023. Each strobe_out pulse is exactly 1 clk, 2 edges after strobe_in rises.
- Step, sel=01, after reset: inputs 400×4 → 100, 200, 300, 400. Then 0×4 → 300, 200, 100, 0.
- Truncation and alternating input, sel=00:
  - inputs 1, 2 → 0, 1
  - then 0, 1000, 0, 1000 → 1, 500, 500, 500
- Mid-stream select change: 16 samples of 800 at sel=10 → 800. Switch to sel=00 and feed 0 → 400 on the very next output.
- Gating: strobe held high for 10 clocks gives a single output. ena=0 on a strobe rise gives no output. rst_n pulse mid-window followed by input 1000 at sel=00 → 500.

Source files
------------

// File: rtl/moving_average_master_pkg.sv
// Shared widths, window-select encodings and tile pin positions for the moving-average filter.
package moving_average_master_pkg;

    localparam int unsigned DATA_W  = 10;
    localparam int unsigned NMAX    = 16;
    localparam int unsigned SEL_W   = 2;

    localparam int unsigned SUM2_W  = DATA_W + 1;
    localparam int unsigned SUM4_W  = DATA_W + 2;
    localparam int unsigned SUM8_W  = DATA_W + 3;
    localparam int unsigned SUM16_W = DATA_W + 4;

    typedef enum logic [SEL_W-1:0] {
        SEL_N2  = 2'b00,
        SEL_N4  = 2'b01,
        SEL_N8  = 2'b10,
        SEL_N16 = 2'b11
    } sel_e;

    localparam int unsigned UIO_STROBE_IN  = 0;
    localparam int unsigned UIO_DIN_HI     = 2;
    localparam int unsigned UIO_SEL        = 6;
    localparam int unsigned UIO_STROBE_OUT = 1;
    localparam int unsigned UIO_DOUT_HI    = 4;

    localparam logic [7:0] UIO_OE_MASK = 8'b0011_0010;

endpackage

// File: rtl/moving_average_core.sv
// Boxcar filter core: strobe edge detect, 16-deep history, four running sums, registered mean.
module moving_average_core
    import moving_average_master_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              strobe_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]  filter_select,
    output logic [DATA_W-1:0] data_out,
    output logic              strobe_out
);

    logic                strobe_d;
    logic                pending;
    logic                accept_c;
    logic [DATA_W-1:0]   hist [NMAX];
    logic [SUM2_W-1:0]   sum2;
    logic [SUM4_W-1:0]   sum4;
    logic [SUM8_W-1:0]   sum8;
    logic [SUM16_W-1:0]  sum16;
    logic [DATA_W-1:0]   avg_c;

    assign accept_c = strobe_in & ~strobe_d & ena;

    // Each sum adds the new sample and drops the one leaving its window (pre-shift tap).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_d <= 1'b0;
            pending  <= 1'b0;
            sum2     <= '0;
            sum4     <= '0;
            sum8     <= '0;
            sum16    <= '0;
            for (int i = 0; i < int'(NMAX); i++) begin
                hist[i] <= '0;
            end
        end else begin
            strobe_d <= strobe_in;
            pending  <= accept_c;
            if (accept_c) begin
                sum2  <= sum2  + SUM2_W'(data_in)  - SUM2_W'(hist[1]);
                sum4  <= sum4  + SUM4_W'(data_in)  - SUM4_W'(hist[3]);
                sum8  <= sum8  + SUM8_W'(data_in)  - SUM8_W'(hist[7]);
                sum16 <= sum16 + SUM16_W'(data_in) - SUM16_W'(hist[15]);
                for (int i = int'(NMAX) - 1; i > 0; i--) begin
                    hist[i] <= hist[i-1];
                end
                hist[0] <= data_in;
            end
        end
    end

    // Window select is applied at the output edge, so a change lands on the next result.
    always_comb begin
        avg_c = DATA_W'(sum16 >> 4);
        case (sel_e'(filter_select))
            SEL_N2:  avg_c = DATA_W'(sum2 >> 1);
            SEL_N4:  avg_c = DATA_W'(sum4 >> 2);
            SEL_N8:  avg_c = DATA_W'(sum8 >> 3);
            SEL_N16: avg_c = DATA_W'(sum16 >> 4);
            default: avg_c = DATA_W'(sum16 >> 4);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            strobe_out <= 1'b0;
        end else begin
            strobe_out <= pending;
            if (pending) begin
                data_out <= avg_c;
            end
        end
    end

endmodule

// File: rtl/moving_average_master.sv
// Tile wrapper: unpacks sample/strobe/select from the pins and packs the filtered result back out.
module moving_average_master
    import moving_average_master_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              strobe_out;
    logic              unused_ok;

    assign data_in   = {uio_in[UIO_DIN_HI +: 2], ui_in};
    assign unused_ok = &{1'b0, uio_in[1], uio_in[5:4]};

    // rst_n keeps its legacy name but is active-high.
    moving_average_core u_core (
        .clk           (clk),
        .rst           (rst_n),
        .ena           (ena),
        .strobe_in     (uio_in[UIO_STROBE_IN]),
        .data_in       (data_in),
        .filter_select (uio_in[UIO_SEL +: SEL_W]),
        .data_out      (data_out),
        .strobe_out    (strobe_out)
    );

    always_comb begin
        uio_out                      = '0;
        uio_out[UIO_STROBE_OUT]      = strobe_out;
        uio_out[UIO_DOUT_HI +: 2]    = data_out[DATA_W-1 -: 2];
    end

    assign uo_out = data_out[7:0];
    assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_moving_average_master.sv
// Self-checking bench for moving_average_master: vector table, corner sequences, random vs. window model.
module tb_moving_average_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic [9:0] din;
    logic [1:0] sel;
    logic       stb;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit rst;
        int sel;
        int data;
        int expv;
    } vec_t;

    vec_t tab[$];
    int   model_hist[16];

    always #5 clk = ~clk;

    // Unused uio bits are driven high to show they are ignored.
    assign ui_in  = din[7:0];
    assign uio_in = {sel, 2'b11, din[9:8], 1'b1, stb};

    moving_average_master dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    function automatic int dout();
        return int'({uio_out[5:4], uo_out});
    endfunction

    function automatic int sout();
        return int'(uio_out[1]);
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic add(input bit r, input int s, input int d, input int e);
        tab.push_back('{rst: r, sel: s, data: d, expv: e});
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) model_hist[i] = 0;
    endfunction

    // Mean of the newest N samples, zero-padded after reset.
    function automatic int model_push(input int d, input int s);
        int n;
        int acc;
        for (int i = 15; i > 0; i--) model_hist[i] = model_hist[i-1];
        model_hist[0] = d;
        n   = 2 << s;
        acc = 0;
        for (int i = 0; i < n; i++) acc += model_hist[i];
        return acc / n;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        stb   = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
    endtask

    // One sample: strobe rises, check strobe_out low after accept edge, high with result one edge later, low again next edge.
    task automatic send(input int d, input int s, input int expv, input string name);
        @(negedge clk);
        din = 10'(d);
        sel = 2'(s);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        check({name, ".pre"}, sout(), 0);
        @(negedge clk);
        check({name, ".stb"}, sout(), 1);
        check({name, ".data"}, dout(), expv);
        check({name, ".zero"}, int'(uio_out & 8'hCD), 0);
        @(negedge clk);
        check({name, ".drop"}, sout(), 0);
        check({name, ".hold"}, dout(), expv);
    endtask

    initial begin
        int pulses;
        int e;
        int d;
        int s;
        int prev_exp;

        rst_n = 1'b1;
        ena   = 1'b1;
        din   = '0;
        sel   = '0;
        stb   = 1'b0;

        // Vector table: ramp-in, step, truncation, mid-stream select change.
        for (int i = 1; i <= 16; i++) add(i == 1, 3, 1023, (1023 * i) / 16);
        add(1, 1, 400, 100); add(0, 1, 400, 200); add(0, 1, 400, 300); add(0, 1, 400, 400);
        add(0, 1, 0, 300);   add(0, 1, 0, 200);   add(0, 1, 0, 100);   add(0, 1, 0, 0);
        add(1, 0, 1, 0);     add(0, 0, 2, 1);
        add(0, 0, 0, 1);     add(0, 0, 1000, 500); add(0, 0, 0, 500);  add(0, 0, 1000, 500);
        for (int i = 1; i <= 16; i++) add(i == 1, 2, 800, 100 * ((i < 8) ? i : 8));
        add(0, 0, 0, 400);

        // Reset state, then idle with no strobe.
        repeat (2) @(negedge clk);
        check("rst.data", dout(), 0);
        check("rst.stb", sout(), 0);
        check("rst.oe", int'(uio_oe), 8'h32);
        check("rst.uio", int'(uio_out), 0);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("idle.data", dout(), 0);
        check("idle.stb", sout(), 0);
        check("idle.oe", int'(uio_oe), 8'h32);

        foreach (tab[i]) begin
            if (tab[i].rst) do_reset();
            send(tab[i].data, tab[i].sel, tab[i].expv, $sformatf("vec%0d", i));
        end

        // Strobe held high for 10 clocks yields exactly one result.
        do_reset();
        @(negedge clk);
        din = 10'd600; sel = 2'd0; stb = 1'b1;
        pulses = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 9) stb = 1'b0;
            pulses += sout();
        end
        check("held.pulses", pulses, 1);
        check("held.data", dout(), 300);

        // Strobe rise while ena=0 is ignored.
        @(negedge clk);
        ena = 1'b0; din = 10'd100; stb = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            pulses += sout();
        end
        stb = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        check("ena.pulses", pulses, 0);
        check("ena.data", dout(), 300);
        send(100, 0, 350, "ena.after");

        // Reset right after an accept clears state and the pending output.
        @(negedge clk);
        din = 10'd900; sel = 2'd0; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        check("midrst.data", dout(), 0);
        check("midrst.stb", sout(), 0);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pulses += sout();
        end
        check("midrst.pulses", pulses, 0);
        check("midrst.idle", dout(), 0);
        send(1000, 0, 500, "midrst.first");

        // Random samples at the minimum 2-clock spacing with random window select.
        do_reset();
        prev_exp = 0;
        for (int n = 0; n <= 200; n++) begin
            @(negedge clk);
            if (n > 0) begin
                check($sformatf("rnd%0d.stb", n), sout(), 1);
                check($sformatf("rnd%0d.data", n), dout(), prev_exp);
            end
            if (n < 200) begin
                d   = int'($urandom_range(0, 1023));
                s   = int'($urandom_range(0, 3));
                din = 10'(d);
                sel = 2'(s);
                stb = 1'b1;
                e   = model_push(d, s);
                prev_exp = e;
                @(negedge clk);
                stb = 1'b0;
                check($sformatf("rnd%0d.gap", n), sout(), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
